// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module : alu_seq_pkg
// Brief  : Shared types and constants for the ALU execute sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ_A = 3'd1,
        ST_READ_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WRITE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_CMP = 2'b01,
        OP_AND = 2'b10,
        OP_MVN = 2'b11
    } opcode_t;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    localparam int STAT_Z = 0;
    localparam int STAT_N = 1;
    localparam int STAT_V = 2;

    function automatic logic [DATA_W-1:0] shift_operand(
        input logic [DATA_W-1:0] value,
        input logic [1:0]        code
    );
        logic [DATA_W-1:0] res;
        case (code)
            SH_LSL1: res = {value[DATA_W-2:0], 1'b0};
            SH_LSR1: res = {1'b0, value[DATA_W-1:1]};
            SH_ASR1: res = {value[DATA_W-1], value[DATA_W-1:1]};
            default: res = value;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_alu.sv
// ============================================================================
// Module : shift_alu
// Brief  : Combinational operand shifter, 16-bit ALU and {V,N,Z} flag logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_alu
    import alu_seq_pkg::*;
(
    input  logic [DATA_W-1:0] rf_data_out,
    input  logic [1:0]        shift,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  opcode_t           opcode,
    output logic [DATA_W-1:0] b_shifted,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        flags
);

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_ovf;

    assign w_sum     = a + b;
    assign w_diff    = a - b;
    assign b_shifted = shift_operand(rf_data_out, shift);

    always_comb begin
        result = '0;
        w_ovf  = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = w_sum;
                w_ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_CMP: begin
                result = w_diff;
                w_ovf  = (a[DATA_W-1] != b[DATA_W-1]) && (w_diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_AND:  result = a & b;
            default: result = ~b;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[STAT_Z] = (result == '0);
        flags[STAT_N] = result[DATA_W-1];
        flags[STAT_V] = w_ovf;
    end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module : alu_sequencer
// Brief  : Four-cycle read/read/execute/write sequencer around an 8x16 regfile.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        opcode,
    input  logic [1:0]        shift,
    input  logic [REG_W-1:0]  rn,
    input  logic [REG_W-1:0]  rm,
    input  logic [REG_W-1:0]  rd,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic [REG_W-1:0]  readnum,
    output logic [REG_W-1:0]  writenum,
    output logic              write,
    output logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [2:0]        status
);

    state_t            r_state;
    state_t            w_next_state;
    opcode_t           r_op;
    logic [1:0]        r_shift;
    logic [REG_W-1:0]  r_rn;
    logic [REG_W-1:0]  r_rm;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_c;
    logic [2:0]        r_status;

    logic [DATA_W-1:0] w_b_shifted;
    logic [DATA_W-1:0] w_result;
    logic [2:0]        w_flags;

    shift_alu u_shift_alu (
        .rf_data_out (rf_data_out),
        .shift       (r_shift),
        .a           (r_a),
        .b           (r_b),
        .opcode      (r_op),
        .b_shifted   (w_b_shifted),
        .result      (w_result),
        .flags       (w_flags)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_READ_A;
            ST_READ_A: w_next_state = ST_READ_B;
            ST_READ_B: w_next_state = ST_EXEC;
            ST_EXEC:   w_next_state = ST_WRITE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Command fields are latched only on accept, so later input changes are inert.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= OP_ADD;
            r_shift  <= SH_NONE;
            r_rn     <= '0;
            r_rm     <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_status <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= opcode_t'(opcode);
                        r_shift <= shift;
                        r_rn    <= rn;
                        r_rm    <= rm;
                        r_rd    <= rd;
                    end
                end
                ST_READ_A: r_a <= rf_data_out;
                ST_READ_B: r_b <= w_b_shifted;
                ST_EXEC: begin
                    r_c      <= w_result;
                    r_status <= w_flags;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        data_in  = '0;
        done     = 1'b0;
        busy     = (r_state != ST_IDLE);
        status   = r_status;
        case (r_state)
            ST_READ_A: readnum = r_rn;
            ST_READ_B: readnum = r_rm;
            ST_WRITE: begin
                writenum = r_rd;
                data_in  = r_c;
                done     = 1'b1;
                write    = (r_op != OP_CMP);
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire
